// File: rtl/medusa_pkg.sv
// Shared WS2812 definitions: default 50 MHz bit timing, encoder state type and
// a parameter legality helper used at elaboration.
package medusa_pkg;

    localparam int WORD_W      = 24;
    localparam int DEF_T0H     = 20;
    localparam int DEF_T1H     = 40;
    localparam int DEF_T_BIT   = 63;
    localparam int DEF_T_RESET = 3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } ws_state_t;

    function automatic bit params_legal(input int t0h, input int t1h,
                                        input int t_bit, input int t_reset);
        return (t0h > 0) && (t0h < t1h) && (t1h < t_bit) && (t_reset >= 1);
    endfunction

endpackage

// File: rtl/ws2812_encoder.sv
// WS2812 serial encoder: shifts out 24-bit GRB words MSB first as pulse-width
// coded bits, then holds the line low for a latch gap when no word follows.
//
// Handshake: a word is taken on any rising edge where pixel_valid_i and
// pixel_ready_o are both high. pixel_ready_o is registered and is high in IDLE
// and in the last cycle of bit 0, so a waiting word chains with no gap.
module ws2812_encoder
    import medusa_pkg::*;
#(
    parameter int T0H     = DEF_T0H,
    parameter int T1H     = DEF_T1H,
    parameter int T_BIT   = DEF_T_BIT,
    parameter int T_RESET = DEF_T_RESET
) (
    input  logic              led_clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] pixel_i,
    input  logic              pixel_valid_i,
    output logic              pixel_ready_o,
    output logic              led_data_o,
    output logic              busy_o,
    output logic              latch_done_o,
    output ws_state_t         state_dbg_o
);

    localparam int PH_W = $clog2(T_BIT);
    localparam int LT_W = $clog2(T_RESET + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_BIT - 1);
    localparam logic [PH_W-1:0] HI_ZERO = PH_W'(T0H);
    localparam logic [PH_W-1:0] HI_ONE  = PH_W'(T1H);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(T_RESET - 1);
    localparam logic [4:0]      BIT_MSB = 5'd23;

    if (!params_legal(T0H, T1H, T_BIT, T_RESET)) begin : g_bad_params
        $error("ws2812_encoder: need 0 < T0H < T1H < T_BIT and T_RESET >= 1");
    end

    ws_state_t         state, state_n;
    logic [PH_W-1:0]   phase_cnt, phase_n;
    logic [4:0]        bit_idx, bit_n;
    logic [LT_W-1:0]   latch_cnt, latch_n;
    logic [WORD_W-1:0] word, word_n;
    logic              led_n;
    logic              ready_n;
    logic              accept;
    logic [PH_W-1:0]   hi_len_n;

    assign accept = pixel_valid_i && pixel_ready_o;

    always_ff @(posedge led_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            phase_cnt     <= '0;
            bit_idx       <= '0;
            latch_cnt     <= '0;
            word          <= '0;
            led_data_o    <= 1'b0;
            pixel_ready_o <= 1'b0;
        end else begin
            state         <= state_n;
            phase_cnt     <= phase_n;
            bit_idx       <= bit_n;
            latch_cnt     <= latch_n;
            word          <= word_n;
            led_data_o    <= led_n;
            pixel_ready_o <= ready_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase_cnt;
        bit_n    = bit_idx;
        latch_n  = latch_cnt;
        word_n   = word;
        led_n    = 1'b0;
        ready_n  = 1'b0;
        hi_len_n = HI_ZERO;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SEND;
                    phase_n = '0;
                    bit_n   = BIT_MSB;
                    word_n  = pixel_i;
                end
            end

            ST_SEND: begin
                if (phase_cnt == PH_LAST) begin
                    phase_n = '0;
                    if (bit_idx != 5'd0) begin
                        bit_n = bit_idx - 5'd1;
                    end else if (accept) begin
                        bit_n  = BIT_MSB;
                        word_n = pixel_i;
                    end else begin
                        state_n = ST_LATCH;
                        latch_n = '0;
                    end
                end else begin
                    phase_n = phase_cnt + PH_W'(1);
                end
            end

            ST_LATCH: begin
                if (latch_cnt == LT_LAST) begin
                    state_n = ST_IDLE;
                    latch_n = '0;
                end else begin
                    latch_n = latch_cnt + LT_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
                phase_n = '0;
                bit_n   = '0;
                latch_n = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the next-cycle view.
        hi_len_n = word_n[bit_n] ? HI_ONE : HI_ZERO;
        led_n    = (state_n == ST_SEND) && (phase_n < hi_len_n);
        ready_n  = (state_n == ST_IDLE) ||
                   ((state_n == ST_SEND) && (bit_n == 5'd0) && (phase_n == PH_LAST));
    end

    assign busy_o       = (state != ST_IDLE);
    assign latch_done_o = (state == ST_LATCH) && (latch_cnt == LT_LAST);
    assign state_dbg_o  = state;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder: cycle-exact waveform scoreboard on a
// small-timing instance plus pulse-width measurements on a default instance.
module tb_ws2812_encoder;
    import medusa_pkg::*;

    localparam int TB_T0H   = 2;
    localparam int TB_T1H   = 4;
    localparam int TB_BIT   = 6;
    localparam int TB_RESET = 10;
    localparam int W        = 4;
    localparam int NREC     = 24 * 63 + 3000 + 10;

    logic        clk;
    logic        rst;
    logic [23:0] dut_pixel;
    logic        dut_valid;
    logic        dut_ready;
    logic        dut_led;
    logic        dut_busy;
    logic        dut_done;
    ws_state_t   dut_state;

    logic [23:0] def_pixel;
    logic        def_valid;
    logic        def_ready;
    logic        def_led;
    logic        def_busy;
    logic        def_done;
    ws_state_t   def_state;

    // expected {busy, led, ready, latch_done} per cycle
    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    ws2812_encoder #(
        .T0H(TB_T0H), .T1H(TB_T1H), .T_BIT(TB_BIT), .T_RESET(TB_RESET)
    ) u_dut (
        .led_clk_i    (clk),
        .rst_i        (rst),
        .pixel_i      (dut_pixel),
        .pixel_valid_i(dut_valid),
        .pixel_ready_o(dut_ready),
        .led_data_o   (dut_led),
        .busy_o       (dut_busy),
        .latch_done_o (dut_done),
        .state_dbg_o  (dut_state)
    );

    ws2812_encoder u_def (
        .led_clk_i    (clk),
        .rst_i        (rst),
        .pixel_i      (def_pixel),
        .pixel_valid_i(def_valid),
        .pixel_ready_o(def_ready),
        .led_data_o   (def_led),
        .busy_o       (def_busy),
        .latch_done_o (def_done),
        .state_dbg_o  (def_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [23:0] w);
        int hi;
        for (int b = 23; b >= 0; b--) begin
            hi = w[b] ? TB_T1H : TB_T0H;
            for (int p = 0; p < TB_BIT; p++)
                exp_q.push_back({1'b1, (p < hi), (b == 0 && p == TB_BIT - 1), 1'b0});
        end
    endtask

    task automatic push_latch();
        for (int i = 0; i < TB_RESET; i++)
            exp_q.push_back({1'b1, 1'b0, 1'b0, (i == TB_RESET - 1)});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(4'b0010);
    endtask

    task automatic step();
        logic [W-1:0] exp;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("wave", 32'({dut_busy, dut_led, dut_ready, dut_done}), 32'(exp));
        end
    endtask

    task automatic step_all();
        while (exp_q.size() > 0) step();
    endtask

    task automatic start_word(input logic [23:0] w);
        dut_pixel = w;
        dut_valid = 1'b1;
        step();
        dut_valid = 1'b0;
    endtask

    initial begin
        int ready_hi;
        logic led_rec [NREC];
        logic done_rec[NREC];
        int rise_q[$];
        int d;
        int ndone;
        int wdt;
        int k;
        logic [23:0] def_word;

        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        dut_pixel = '0;
        dut_valid = 1'b0;
        def_pixel = '0;
        def_valid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_led",   32'(dut_led),   32'd0);
        check("rst_ready", 32'(dut_ready), 32'd0);
        check("rst_busy",  32'(dut_busy),  32'd0);
        check("rst_done",  32'(dut_done),  32'd0);
        check("rst_state", 32'(dut_state), 32'(ST_IDLE));
        check("rst_def_ready", 32'(def_ready), 32'd0);
        check("rst_def_state", 32'(def_state), 32'(ST_IDLE));
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(dut_ready), 32'd0);
        push_idle(2);
        step_all();

        // single word: one leading 1, then 23 zeros, latch gap, back to idle
        push_word(24'h800000);
        push_latch();
        push_idle(2);
        start_word(24'h800000);
        step_all();

        // back-to-back words with valid held high
        push_word(24'hFFFFFF);
        push_word(24'h000000);
        push_latch();
        push_idle(1);
        dut_pixel = 24'hFFFFFF;
        dut_valid = 1'b1;
        ready_hi  = 0;
        for (int i = 0; i < 288; i++) begin
            step();
            if (dut_ready) ready_hi++;
            if (i == 143) dut_pixel = 24'h000000;
            if (i == 287) dut_valid = 1'b0;
        end
        check("b2b_ready_pulses", 32'(ready_hi), 32'd2);
        step_all();

        // underrun into latch; a word offered during latch waits for idle
        push_word(24'h123456);
        push_latch();
        push_idle(1);
        push_word(24'h0F0F0F);
        push_latch();
        push_idle(1);
        start_word(24'h123456);
        repeat (146) step();
        check("underrun_in_latch", 32'(dut_state), 32'(ST_LATCH));
        dut_pixel = 24'h0F0F0F;
        dut_valid = 1'b1;
        repeat (9) step();
        dut_valid = 1'b0;
        step_all();

        // reset in the middle of a word while the line is high
        push_word(24'hA5A5A5);
        start_word(24'hA5A5A5);
        repeat (50) step();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_led",   32'(dut_led),   32'd0);
        check("rst_mid_busy",  32'(dut_busy),  32'd0);
        check("rst_mid_ready", 32'(dut_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_ready", 32'(dut_ready), 32'd0);
        push_idle(1);
        step();
        push_word(24'h0000FF);
        push_latch();
        push_idle(1);
        start_word(24'h0000FF);
        step_all();

        // valid and pixel glitching while ready is low
        push_word(24'h5A3C96);
        push_latch();
        push_idle(1);
        start_word(24'h5A3C96);
        for (int i = 0; i < 143; i++) begin
            dut_valid = (i < 142) ? ((i % 3) != 0) : 1'b0;
            dut_pixel = ~dut_pixel;
            step();
        end
        step_all();

        // default timing instance: measure widths, periods and the gap
        def_word  = 24'h00FF00;
        def_pixel = def_word;
        def_valid = 1'b1;
        for (int i = 0; i < NREC; i++) begin
            @(negedge clk);
            led_rec[i]  = def_led;
            done_rec[i] = def_done;
            if (i == 0) def_valid = 1'b0;
        end
        d     = -1;
        ndone = 0;
        for (int i = 0; i < NREC; i++) begin
            if (led_rec[i] && (i == 0 || !led_rec[i - 1])) rise_q.push_back(i);
            if (done_rec[i]) begin
                ndone++;
                if (d < 0) d = i;
            end
        end
        check("def_rise_count", 32'(rise_q.size()), 32'd24);
        check("def_done_count", 32'(ndone), 32'd1);
        if (rise_q.size() > 0) check("def_latency", 32'(rise_q[0]), 32'd0);
        for (int j = 0; j < rise_q.size() && j < 24; j++) begin
            wdt = 0;
            k   = rise_q[j];
            while (k < NREC && led_rec[k]) begin
                wdt++;
                k++;
            end
            check("def_high_width", 32'(wdt), def_word[23 - j] ? 32'd40 : 32'd20);
            if (j > 0) check("def_bit_period", 32'(rise_q[j] - rise_q[j - 1]), 32'd63);
        end
        if (rise_q.size() == 24)
            check("def_latch_gap", 32'(d - (rise_q[23] + 63) + 1), 32'd3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
